// File: rtl/code_sequencer.sv
// Code sequencer: debounced pushbutton plus optional auto-advance stepping a
// 3-bit message-selection code, with a one-cycle step pulse per change.
module code_sequencer #(
  parameter int         DB_CYCLES   = 1000000,
  parameter int         STEP_CYCLES = 50000000,
  parameter logic [2:0] LAST_CODE   = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic       auto,
  input  logic       dir,
  output logic [2:0] code,
  output logic       step_pulse
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int PSW = $clog2(STEP_CYCLES);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);
  localparam logic [PSW-1:0] PS_MAX = PSW'(STEP_CYCLES - 1);

  typedef enum logic {S_MANUAL, S_AUTO} state_t;

  logic           k1, k2, a1, a2;
  logic           kst;
  logic [DBW-1:0] db_cnt;
  logic [PSW-1:0] presc;
  state_t         state;
  logic           press, tc, advance;
  logic [2:0]     code_nxt;

  // A press is the cycle the debounced level is about to fall 1->0.
  always_comb begin
    press   = (k2 != kst) && (db_cnt == DB_MAX) && !k2;
    tc      = (state == S_AUTO) && (presc == PS_MAX);
    advance = press || tc;
    if (dir) code_nxt = (code == 3'd0) ? LAST_CODE : code - 3'd1;
    else     code_nxt = (code == LAST_CODE) ? 3'd0 : code + 3'd1;
  end

  // Two-flop synchronizers for the asynchronous key and switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      k1 <= 1'b1;
      k2 <= 1'b1;
      a1 <= 1'b0;
      a2 <= 1'b0;
    end else begin
      k1 <= key_n;
      k2 <= k1;
      a1 <= auto;
      a2 <= a1;
    end
  end

  // Debouncer: accept a new key level after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      kst    <= 1'b1;
      db_cnt <= '0;
    end else if (k2 != kst) begin
      if (db_cnt == DB_MAX) begin
        kst    <= k2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Mode FSM, prescaler and code register; the advance uses the pre-edge mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_MANUAL;
      presc      <= '0;
      code       <= 3'd0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= advance;
      if (advance) code <= code_nxt;
      case (state)
        S_MANUAL: begin
          presc <= '0;
          if (a2) state <= S_AUTO;
        end
        S_AUTO: begin
          if (!a2) begin
            state <= S_MANUAL;
            presc <= '0;
          end else if (advance) begin
            presc <= '0;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: begin
          state <= S_MANUAL;
          presc <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/code_sequencer.md
CODE_SEQUENCER -- requirements
Module: code_sequencer

Interface
REQ-001 Parameter DB_CYCLES, default 1000000: consecutive cycles a changed key level must persist before acceptance (20 ms at 50 MHz); legal range >= 1.
REQ-002 Parameter STEP_CYCLES, default 50000000: auto-advance period in clock cycles; legal range >= 2.
REQ-003 Parameter LAST_CODE, default 3'd7: highest code emitted; legal range 0..7.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port key_n, input, 1: raw asynchronous pushbutton, active-low, bouncing.
REQ-007 Port auto, input, 1: raw asynchronous slide switch; 1 selects auto-advance mode.
REQ-008 Port dir, input, 1: step direction; 0 counts up, 1 counts down; sampled directly at each advance.
REQ-009 Port code, output, 3: registered selection code for the downstream 7-segment message decoder.
REQ-010 Port step_pulse, output, 1: registered; high for exactly one cycle, on the same cycle as each code change.

Function
REQ-011 key_n and auto each pass through a 2-flop synchronizer (k1/k2, a1/a2) before any other use.
REQ-012 Debouncer holds a stable level kst and a counter: each cycle k2 != kst, the counter increments; each cycle k2 == kst, the counter clears.
REQ-013 When k2 != kst and the counter equals DB_CYCLES-1, kst <= k2 and the counter clears on that edge.
REQ-014 A press event occurs on the edge where kst flips 1->0; a 1->0 flip is the only press event; release (0->1) produces no event.
REQ-015 Latency: with key_n held low, code changes on the (DB_CYCLES+2)th rising edge, counting the first edge that samples key_n low.
REQ-016 Bounces shorter than DB_CYCLES consecutive cycles produce no event; a held key produces exactly one event.
REQ-017 FSM states MANUAL and AUTO; MANUAL -> AUTO on the edge where a2 = 1; AUTO -> MANUAL on the edge where a2 = 0.
REQ-018 In MANUAL, each press event advances code once; the prescaler is held at 0.
REQ-019 In AUTO, the prescaler counts 0..STEP_CYCLES-1; at STEP_CYCLES-1 it advances code and wraps to 0, giving one advance per STEP_CYCLES cycles.
REQ-020 On entry to AUTO, the prescaler starts from 0; the first auto advance occurs STEP_CYCLES cycles after the entry edge.
REQ-021 A press event in AUTO advances code immediately and clears the prescaler.
REQ-022 A press and a terminal count on the same cycle cause one advance only; the prescaler clears.
REQ-023 Advance up: code == LAST_CODE -> 0, else code+1.
REQ-024 Advance down: code == 0 -> LAST_CODE, else code-1.
REQ-025 code never exceeds LAST_CODE; LAST_CODE = 0 holds code at 0 but still pulses step_pulse on each advance.
REQ-026 A mode change and a press on the same cycle: the press is honoured under the old state's rules, and the state changes on the same edge.

Reset
REQ-027 On a rising edge with rst = 1: code = 0, step_pulse = 0, state = MANUAL, k1 = k2 = kst = 1, a1 = a2 = 0, debounce counter = 0, prescaler = 0.
REQ-028 rst asserted mid-debounce or mid-period discards partial counts; no event or advance is generated from pre-reset history.
REQ-029 rst has priority over every other input on the same edge.

Verification
(Run with DB_CYCLES = 4, STEP_CYCLES = 10, LAST_CODE = 7 unless noted.)
REQ-030 Reset, then key_n held low -> code goes 0 -> 1 on the 6th edge, with step_pulse high for that one cycle only; holding key for 100 cycles gives no further change.
REQ-031 key_n toggled low 3 cycles / high 3 cycles for 30 cycles, then held high -> code stays 0 and step_pulse never asserts.
REQ-032 dir = 1, one clean press from code 0 -> code = 7; with LAST_CODE = 5, 6 up-presses from 0 -> codes 1, 2, 3, 4, 5, 0.
REQ-033 auto = 1 held -> after synchronization, code advances every 10 cycles; a press event on a terminal-count cycle -> single advance, and the next auto step comes 10 cycles later.
REQ-034 rst pulsed for one cycle while in AUTO with code = 4 and the prescaler at 7 -> code = 0, step_pulse = 0, state MANUAL until a2 re-synchronizes, then the first step comes 10 cycles after entry.
